// File: rtl/rom_arbiter.sv
// Two-requester round-robin arbiter in front of a registered-output ROM.
// One read is in flight at a time: accept, issue, capture, respond.
module rom_arbiter #(
   parameter int DATA_DEPTH = 5
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               req0_valid,
   input  logic signed [31:0] req0_addr,
   output logic               req0_ready,
   input  logic               req1_valid,
   input  logic signed [31:0] req1_addr,
   output logic               req1_ready,
   output logic [1:0]         resp_valid,
   input  logic [1:0]         resp_ready,
   output logic signed [31:0] resp_data,
   output logic               resp_err,
   output logic               rom_read,
   output logic signed [31:0] rom_addr,
   input  logic signed [31:0] rom_data
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      CAPTURE = 2'd2,
      RESP    = 2'd3
   } state_t;

   // Negative addresses have bit 31 set; anything at or above the depth has high bits set.
   function automatic logic in_range(input logic signed [31:0] a);
      logic [31:0] u;
      u = a;
      return (u[31] == 1'b0) && ((u >> DATA_DEPTH) == 32'd0);
   endfunction

   state_t             state_r;
   state_t             state_s;
   logic               last_grant_r;
   logic               gnt_r;
   logic               gnt_s;
   logic               accept_s;
   logic signed [31:0] addr_r;
   logic signed [31:0] sel_addr_s;
   logic               err_r;
   logic               rom_read_r;
   logic signed [31:0] rom_addr_r;
   logic [1:0]         resp_valid_r;
   logic signed [31:0] resp_data_r;
   logic               resp_err_r;

   // Next-state, arbitration and combinational ready decode
   always_comb begin
      state_s    = state_r;
      accept_s   = 1'b0;
      gnt_s      = 1'b0;
      sel_addr_s = req0_addr;
      case (state_r)
         IDLE: begin
            if (rst_n && (req0_valid || req1_valid)) begin
               accept_s = 1'b1;
               if (req0_valid && req1_valid) begin
                  gnt_s = ~last_grant_r;
               end else if (req1_valid) begin
                  gnt_s = 1'b1;
               end else begin
                  gnt_s = 1'b0;
               end
               state_s = ISSUE;
            end else begin
               state_s = IDLE;
            end
         end
         ISSUE:   state_s = CAPTURE;
         CAPTURE: state_s = RESP;
         RESP: begin
            if (resp_ready[gnt_r]) begin
               state_s = IDLE;
            end else begin
               state_s = RESP;
            end
         end
         default: state_s = IDLE;
      endcase
      if (gnt_s) begin
         sel_addr_s = req1_addr;
      end else begin
         sel_addr_s = req0_addr;
      end
      req0_ready = accept_s && !gnt_s;
      req1_ready = accept_s && gnt_s;
   end

   // State, transaction context and all registered outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r      <= IDLE;
         last_grant_r <= 1'b1;
         gnt_r        <= 1'b0;
         addr_r       <= 32'sd0;
         err_r        <= 1'b0;
         rom_read_r   <= 1'b0;
         rom_addr_r   <= 32'sd0;
         resp_valid_r <= 2'b00;
         resp_data_r  <= 32'sd0;
         resp_err_r   <= 1'b0;
      end else begin
         state_r <= state_s;
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  addr_r     <= sel_addr_s;
                  gnt_r      <= gnt_s;
                  rom_read_r <= in_range(sel_addr_s);
                  if (in_range(sel_addr_s)) begin
                     rom_addr_r <= sel_addr_s;
                  end
               end
            end
            ISSUE: begin
               rom_read_r <= 1'b0;
               err_r      <= !in_range(addr_r);
            end
            CAPTURE: begin
               resp_data_r  <= err_r ? 32'sd0 : rom_data;
               resp_err_r   <= err_r;
               resp_valid_r <= gnt_r ? 2'b10 : 2'b01;
            end
            RESP: begin
               if (resp_ready[gnt_r]) begin
                  resp_valid_r <= 2'b00;
                  last_grant_r <= gnt_r;
               end
            end
            default: ;
         endcase
      end
   end

   assign rom_read   = rom_read_r;
   assign rom_addr   = rom_addr_r;
   assign resp_valid = resp_valid_r;
   assign resp_data  = resp_data_r;
   assign resp_err   = resp_err_r;

endmodule

// File: doc/rom_arbiter.md
ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_DEPTH, default 5, meaning the ROM holds 2**DATA_DEPTH 32-bit words.
REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clk  in  1  single clock; all state changes on posedge.
- rst_n  in  1  reset, synchronous and active-low.
- req0_valid  in  1  requester 0 read request.
- req0_addr  in  32 signed  requester 0 word address.
- req0_ready  out  1  requester 0 request accepted this cycle.
- req1_valid  in  1  requester 1 read request.
- req1_addr  in  32 signed  requester 1 word address.
- req1_ready  out  1  requester 1 request accepted this cycle.
- resp_valid  out  2  one-hot; bit g means the response belongs to requester g.
- resp_ready  in  2  bit g means requester g takes the response.
- resp_data  out  32 signed  read word; 0 when resp_err is high.
- resp_err  out  1  the address was out of range.
- rom_read  out  1  ROM read enable.
- rom_addr  out  32 signed  ROM address.
- rom_data  in  32 signed  ROM registered output; valid 1 cycle after rom_read.

Function
REQ-003 The FSM SHALL have states IDLE, ISSUE, CAPTURE and RESP, and one transaction SHALL be outstanding at most.
REQ-004 In IDLE with at least one reqX_valid high, the block SHALL grant one requester, drive that reqX_ready high combinationally, latch its address and grant index, and go to ISSUE.
- Other states: req0_ready = req1_ready = 0.
REQ-005 Arbitration SHALL be round-robin.
- If both requesters are valid, grant the one not recorded in last_grant.
- If one is valid, grant it regardless of last_grant.
REQ-006 last_grant SHALL update when a response completes, meaning resp_valid and the matching resp_ready are both high.
REQ-007 An address is out of range if negative or >= 2**DATA_DEPTH.
- ISSUE, in range: rom_read = 1 and rom_addr = latched address, for exactly one cycle.
- ISSUE, out of range: rom_read = 0 and an error flag is set.
- Both cases: go to CAPTURE next.
REQ-008 In CAPTURE the block SHALL register resp_data (rom_data in range, else 0) and resp_err, then go to RESP.
REQ-009 In RESP, resp_valid SHALL be one-hot on the granted index.
- resp_data and resp_err held stable until resp_ready[g] is high.
- Then go to IDLE with resp_valid = 0 in the next cycle.
- resp_ready on the non-granted bit SHALL be ignored.
REQ-010 Latency SHALL be fixed:
- Acceptance cycle T.
- rom_read high in T+1.
- Capture at the end of T+2.
- resp_valid first high in T+3.
- Minimum request-to-request spacing: 4 cycles.
REQ-011 rom_read, rom_addr, resp_valid, resp_data and resp_err SHALL be driven from registers or state decode, with no combinational path from request inputs.
- Only reqX_ready is combinational from reqX_valid.
REQ-012 Outside ISSUE, rom_read SHALL be 0 and rom_addr SHALL hold its last value.
REQ-013 A requester dropping reqX_valid after acceptance SHALL NOT cancel the transaction.

Reset
REQ-014 With rst_n = 0 at a posedge, the following SHALL hold:
- state = IDLE.
- last_grant = 1, so requester 0 wins the first contention.
- resp_valid = 0, resp_data = 0, resp_err = 0.
- rom_read = 0, rom_addr = 0.
- Latched address and grant index cleared.
REQ-015 Reset asserted mid-transaction SHALL abandon the transaction with no response and return to IDLE on the same edge.
- Any ROM read already issued is ignored.
REQ-016 req0_ready and req1_ready SHALL be 0 while rst_n = 0.

Verification
REQ-017 The bench SHALL cover at least these directed scenarios:
- Single read: ROM word 3 = 0x0000ABCD; req0 addr 3 at T -> req0_ready at T, rom_read/rom_addr = 3 at T+1, resp_valid = 01 with data 0x0000ABCD and err 0 at T+3.
- Contention after reset: both valid at once, addr 1 and 2, resp_ready tied high -> req0 served first; then req1, accepted at T+4 with its response at T+7.
- Fairness: both valid continuously for 6 transactions -> grant order 0,1,0,1,0,1.
- Out of range, DATA_DEPTH = 5: addr 32 and addr -1 -> rom_read never high; resp_data = 0 and resp_err = 1 at T+3.
- Backpressure: resp_ready held 0 for 5 cycles in RESP -> resp_valid and resp_data stable, no new acceptance; completion 1 cycle after resp_ready rises.
- Reset mid-transaction: rst_n = 0 at T+2 -> no resp_valid; the next request after release gets full T..T+3 timing.
